normalize_shifter: RTL and testbench

Multi-cycle normalizer that computes the shift amount the barrel shifter consumes, rather than consuming one. Given a 32-bit operand, it finds the leading-zero count (left mode) or trailing-zero count (right mode) by binary search. It shifts the operand until bit 31 (left) or bit 0 (right) is set and returns both the normalized value and the count. It sits beside the ALU shift path and feeds the 6-bit count straight into the shifter's `shift` input for FP-style normalization and priority-encode operations.

---
 rtl/normalize_shifter.sv | 115 +++++++++++
 tb/tb_normalize_shifter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/normalize_shifter.sv
// Multi-cycle leading/trailing-zero normalizer: binary search over stage widths 16,8,4,2,1.
// Produces the normalized operand and the 6-bit zero count for the barrel shifter.
module normalize_shifter (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] operand,
    input  logic        leftNotRight,
    output logic [31:0] result,
    output logic [5:0]  shift,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // S_IDLE | waiting for start
    // S_STEP | one binary-search stage per cycle, r_stage 0..4
    // S_DONE | outputs valid, done high; start here re-launches
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_work;
    logic [5:0]  r_cnt;
    logic [2:0]  r_stage;
    logic        r_left;
    logic        r_zero_op;

    logic [5:0]  w_width;
    logic [31:0] w_mask_hi;
    logic [31:0] w_mask_lo;
    logic        w_all_zero;
    logic [31:0] w_work_nxt;
    logic [5:0]  w_cnt_nxt;

    always_comb begin
        w_width = 6'd1;
        case (r_stage)
            3'd0:    w_width = 6'd16;
            3'd1:    w_width = 6'd8;
            3'd2:    w_width = 6'd4;
            3'd3:    w_width = 6'd2;
            default: w_width = 6'd1;
        endcase
    end

    always_comb begin
        w_mask_hi  = ~(32'hFFFF_FFFF >> w_width);
        w_mask_lo  = ~(32'hFFFF_FFFF << w_width);
        w_all_zero = r_left ? ((r_work & w_mask_hi) == 32'd0)
                            : ((r_work & w_mask_lo) == 32'd0);
        w_work_nxt = r_work;
        w_cnt_nxt  = r_cnt;
        if (w_all_zero) begin
            w_work_nxt = r_left ? (r_work << w_width) : (r_work >> w_width);
            w_cnt_nxt  = r_cnt + w_width;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_work    <= 32'd0;
            r_cnt     <= 6'd0;
            r_stage   <= 3'd0;
            r_left    <= 1'b0;
            r_zero_op <= 1'b0;
            result    <= 32'd0;
            shift     <= 6'd0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_work    <= operand;
                        r_left    <= leftNotRight;
                        r_cnt     <= 6'd0;
                        r_stage   <= 3'd0;
                        r_zero_op <= (operand == 32'd0);
                        zero      <= (operand == 32'd0);
                        busy      <= 1'b1;
                        r_state   <= S_STEP;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    r_work <= w_work_nxt;
                    r_cnt  <= w_cnt_nxt;
                    if (r_stage == 3'd4) begin
                        // A zero operand runs all stages but reports a full-width count.
                        r_stage <= 3'd0;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= r_zero_op ? 32'd0 : w_work_nxt;
                        shift   <= r_zero_op ? 6'd32 : w_cnt_nxt;
                        zero    <= r_zero_op;
                    end else begin
                        r_stage <= r_stage + 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_normalize_shifter.sv
// Self-checking bench for normalize_shifter: directed cases, random operands vs a
// bit-at-a-time reference normalizer, start-while-busy, back-to-back and mid-run reset.
module tb_normalize_shifter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [31:0] operand = 32'd0;
    logic        leftNotRight = 1'b0;
    logic [31:0] result;
    logic [5:0]  shift;
    logic        zero;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;

    normalize_shifter dut (
        .CLK(CLK), .RST(RST), .start(start), .operand(operand),
        .leftNotRight(leftNotRight), .result(result), .shift(shift),
        .zero(zero), .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    function automatic void model(input logic [31:0] op, input logic left,
                                  output logic [31:0] r, output logic [5:0] s,
                                  output logic z);
        r = op;
        s = 6'd0;
        z = (op == 32'd0);
        if (z) begin
            r = 32'd0;
            s = 6'd32;
        end else begin
            while (left ? !r[31] : !r[0]) begin
                r = left ? (r << 1) : (r >> 1);
                s = s + 6'd1;
            end
        end
    endfunction

    // Launches one request and waits for done; reports latency in edges after accept
    // (0 means the bound expired) and whether result/shift moved before completion.
    task automatic launch_and_wait(input logic [31:0] op, input logic left,
                                   output int lat, output logic early);
        logic [31:0] r0;
        logic [5:0]  s0;
        operand = op;
        leftNotRight = left;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        operand = $urandom;
        leftNotRight = $urandom_range(0, 1);
        r0 = result;
        s0 = shift;
        early = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                lat = i;
                break;
            end
            if (result !== r0 || shift !== s0) early = 1'b1;
        end
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        total++;
        if ({result, shift, zero, busy, done} !== 41'd0) begin
            bad++;
            $display("FAIL reset_outputs: got result=%h shift=%0d zero=%b busy=%b done=%b, want all 0",
                     result, shift, zero, busy, done);
        end
    endtask

    task automatic test_directed;
        logic [31:0] ops [7] = '{32'h0000_0001, 32'h00F0_0000, 32'h8000_0000,
                                 32'h8000_0000, 32'h0000_0C00, 32'h0000_0000, 32'h0000_0000};
        logic        lft [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] er [7]  = '{32'h8000_0000, 32'hF000_0000, 32'h8000_0000,
                                 32'h0000_0001, 32'h0000_0003, 32'h0, 32'h0};
        logic [5:0]  es [7]  = '{6'd31, 6'd8, 6'd0, 6'd31, 6'd10, 6'd32, 6'd32};
        logic        ez [7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int lat;
        logic early;
        for (int k = 0; k < 7; k++) begin
            launch_and_wait(ops[k], lft[k], lat, early);
            total++;
            if (lat !== 5) begin
                bad++;
                $display("FAIL dir_latency[%0d]: got %0d edges, want 5", k, lat);
            end
            total++;
            if (result !== er[k] || shift !== es[k] || zero !== ez[k] || busy !== 1'b0) begin
                bad++;
                $display("FAIL dir_result[%0d]: got %h/%0d/z%b/b%b, want %h/%0d/z%b/b0",
                         k, result, shift, zero, busy, er[k], es[k], ez[k]);
            end
            @(posedge CLK);
            #1;
            total++;
            if (done !== 1'b0 || result !== er[k] || shift !== es[k]) begin
                bad++;
                $display("FAIL dir_hold[%0d]: got done=%b %h/%0d, want done=0 %h/%0d",
                         k, done, result, shift, er[k], es[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] op, mr;
        logic [5:0]  ms;
        logic        mz, left;
        int lat;
        logic early;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 3))
                0: op = $urandom >> $urandom_range(0, 31);
                1: op = $urandom << $urandom_range(0, 31);
                2: op = 32'd1 << $urandom_range(0, 31);
                default: op = (k % 10 == 0) ? 32'd0 : $urandom;
            endcase
            left = $urandom_range(0, 1);
            model(op, left, mr, ms, mz);
            launch_and_wait(op, left, lat, early);
            total++;
            if (lat !== 5 || early !== 1'b0) begin
                bad++;
                $display("FAIL rnd_timing[%0d]: got lat=%0d early=%b, want lat=5 early=0", k, lat, early);
            end
            total++;
            if (result !== mr || shift !== ms || zero !== mz) begin
                bad++;
                $display("FAIL rnd_result[%0d]: op=%h left=%b got %h/%0d/z%b, want %h/%0d/z%b",
                         k, op, left, result, shift, zero, mr, ms, mz);
            end
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_start_ignored;
        logic [31:0] mr;
        logic [5:0]  ms;
        logic        mz;
        int lat;
        model(32'h0001_2340, 1'b1, mr, ms, mz);
        operand = 32'h0001_2340;
        leftNotRight = 1'b1;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(posedge CLK);
        #1;
        operand = 32'h0000_0080;
        leftNotRight = 1'b0;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL ign_busy: got busy=%b, want 1", busy);
        end
        lat = 0;
        for (int i = 3; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 5 || result !== mr || shift !== ms) begin
            bad++;
            $display("FAIL ign_result: got lat=%0d %h/%0d, want lat=5 %h/%0d", lat, result, shift, mr, ms);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] mr;
        logic [5:0]  ms;
        logic        mz;
        int lat;
        logic early;
        launch_and_wait(32'h0000_0300, 1'b0, lat, early);
        total++;
        if (lat !== 5 || result !== 32'h0000_0003 || shift !== 6'd8) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d %h/%0d, want lat=5 00000003/8", lat, result, shift);
        end
        model(32'h0000_1000, 1'b1, mr, ms, mz);
        operand = 32'h0000_1000;
        leftNotRight = 1'b1;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || result !== 32'h0000_0003) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b result=%h, want busy=1 done=0 result=00000003",
                     busy, done, result);
        end
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        total++;
        if (lat !== 5 || result !== mr || shift !== ms || zero !== mz) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d %h/%0d, want lat=5 %h/%0d", lat, result, shift, mr, ms);
        end
    endtask

    task automatic test_reset_mid;
        logic seen;
        int lat;
        logic early;
        operand = 32'h0000_0010;
        leftNotRight = 1'b1;
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        total++;
        if ({result, shift, zero, busy, done} !== 41'd0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got %h/%0d z%b b%b d%b, want all 0",
                     result, shift, zero, busy, done);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge CLK);
            #1;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_quiet: got activity after abort, want none");
        end
        launch_and_wait(32'h0000_0010, 1'b1, lat, early);
        total++;
        if (lat !== 5 || result !== 32'h8000_0000 || shift !== 6'd27) begin
            bad++;
            $display("FAIL rst_mid_resume: got lat=%0d %h/%0d, want lat=5 80000000/27", lat, result, shift);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
